// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID check master: FSM states, sysid word
// addresses and the default build timestamp also used by the software header generator.
package sysid_pkg;

  localparam int DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [DATA_W-1:0] SYSID_DEFAULT_TS = 32'd1361364706;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_LAT,
    ST_TS_REQ,
    ST_TS_LAT,
    ST_FIN
  } sysid_state_e;

  function automatic logic word_mismatch(input logic [DATA_W-1:0] got,
                                         input logic [DATA_W-1:0] want);
    return got != want;
  endfunction

endpackage

// File: rtl/sysid_check_master_if.sv
// Avalon-MM read-only link between the sysid check master and the system-ID slave.
interface sysid_check_master_if;
  import sysid_pkg::*;

  logic              avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_check_master.sv
// Reads the system-ID slave (ID word, then timestamp word) after reset or on request
// and reports whether the running hardware matches the image software expects.
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID    = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int                READ_LATENCY   = 0,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter bit                AUTO_START     = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  sysid_check_master_if.master avm,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                id_mismatch,
  output logic                ts_mismatch,
  output logic                timeout,
  output logic [DATA_W-1:0]   captured_id,
  output logic [DATA_W-1:0]   captured_ts
);

  // One counter serves both the stall timeout and the read-latency wait.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > 3) ? TIMEOUT_CYCLES : 3;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  sysid_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              auto_q, auto_d;
  logic              pass_q, pass_d;
  logic              id_mis_q, id_mis_d;
  logic              ts_mis_q, ts_mis_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] cap_id_q, cap_id_d;
  logic [DATA_W-1:0] cap_ts_q, cap_ts_d;
  logic              cap_now;
  logic              is_id;

  assign is_id = (state_q == ST_ID_REQ) || (state_q == ST_ID_LAT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    auto_d   = auto_q;
    pass_d   = pass_q;
    id_mis_d = id_mis_q;
    ts_mis_d = ts_mis_q;
    to_d     = to_q;
    cap_id_d = cap_id_q;
    cap_ts_d = cap_ts_q;
    cap_now  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          auto_d   = 1'b0;
          pass_d   = 1'b0;
          id_mis_d = 1'b0;
          ts_mis_d = 1'b0;
          to_d     = 1'b0;
          cap_id_d = '0;
          cap_ts_d = '0;
          cnt_d    = '0;
          state_d  = ST_ID_REQ;
        end
      end
      ST_ID_REQ, ST_TS_REQ: begin
        if (avm.avm_waitrequest) begin
          if (cnt_q == TO_LAST) begin
            to_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
          if (READ_LATENCY == 0) begin
            cap_now = 1'b1;
            state_d = is_id ? ST_TS_REQ : ST_FIN;
          end else begin
            state_d = is_id ? ST_ID_LAT : ST_TS_LAT;
          end
        end
      end
      ST_ID_LAT, ST_TS_LAT: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          cap_now = 1'b1;
          state_d = is_id ? ST_TS_REQ : ST_FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (cap_now) begin
      if (is_id) begin
        cap_id_d = avm.avm_readdata;
        id_mis_d = word_mismatch(avm.avm_readdata, EXPECTED_ID);
      end else begin
        cap_ts_d = avm.avm_readdata;
        ts_mis_d = word_mismatch(avm.avm_readdata, EXPECTED_TS);
      end
    end

    // Verdict is registered on entry to FIN so it is already valid alongside done.
    if ((state_d == ST_FIN) && (state_q != ST_FIN)) begin
      pass_d = !to_d && !id_mis_d && !ts_mis_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      auto_q   <= AUTO_START;
      pass_q   <= 1'b0;
      id_mis_q <= 1'b0;
      ts_mis_q <= 1'b0;
      to_q     <= 1'b0;
      cap_id_q <= '0;
      cap_ts_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      auto_q   <= auto_d;
      pass_q   <= pass_d;
      id_mis_q <= id_mis_d;
      ts_mis_q <= ts_mis_d;
      to_q     <= to_d;
      cap_id_q <= cap_id_d;
      cap_ts_q <= cap_ts_d;
    end
  end

  // Bus and status outputs decode straight from registered state, so reset clears them at once.
  assign avm.avm_read    = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
  assign avm.avm_address = (state_q == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy            = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done            = (state_q == ST_FIN);
  assign pass            = pass_q;
  assign id_mismatch     = id_mis_q;
  assign ts_mismatch     = ts_mis_q;
  assign timeout         = to_q;
  assign captured_id     = cap_id_q;
  assign captured_ts     = cap_ts_q;

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench: dut0 is a zero-latency, auto-starting instance; dut1 has read latency 2,
// an 8-cycle timeout and no auto start.
module tb_sysid_check_master;
  import sysid_pkg::*;

  localparam logic [31:0] TS_OK   = 32'd1361364706;
  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n, start0, start1, wr0, wr1;
  logic busy0, done0, pass0, idm0, tsm0, to0;
  logic busy1, done1, pass1, idm1, tsm1, to1;
  logic [31:0] cid0, cts0, cid1, cts1;
  logic [31:0] slave_id0, slave_ts0, slave_id1, slave_ts1;
  int checks = 0;
  int errors = 0;

  sysid_check_master_if bus0();
  sysid_check_master_if bus1();

  sysid_check_master #(
    .EXPECTED_ID(32'd0), .EXPECTED_TS(TS_OK), .READ_LATENCY(0),
    .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
  ) dut0 (
    .clock(clk), .reset_n(rst0_n), .start(start0), .avm(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .id_mismatch(idm0),
    .ts_mismatch(tsm0), .timeout(to0), .captured_id(cid0), .captured_ts(cts0)
  );

  sysid_check_master #(
    .EXPECTED_ID(32'd0), .EXPECTED_TS(TS_OK), .READ_LATENCY(2),
    .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
  ) dut1 (
    .clock(clk), .reset_n(rst1_n), .start(start1), .avm(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .id_mismatch(idm1),
    .ts_mismatch(tsm1), .timeout(to1), .captured_id(cid1), .captured_ts(cts1)
  );

  // Slave 0: combinational data, stall under bench control.
  assign bus0.avm_waitrequest = wr0;
  always_comb bus0.avm_readdata = (bus0.avm_address == SYSID_ADDR_TS) ? slave_ts0 : slave_id0;

  // Slave 1: data valid only on the cycle two edges after accept, garbage otherwise.
  logic p1_v = 1'b0, p1_a = 1'b0, p2_v = 1'b0, p2_a = 1'b0;
  always @(posedge clk) begin
    p1_v <= bus1.avm_read && !bus1.avm_waitrequest;
    p1_a <= bus1.avm_address;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign bus1.avm_waitrequest = wr1;
  always_comb bus1.avm_readdata = p2_v ? (p2_a ? slave_ts1 : slave_id1) : GARBAGE;

  task automatic pulse_start0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  task automatic pulse_start1();
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  // Returns negedges waited until done is seen; 0 means the bound expired.
  task automatic wait_done0(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin cyc = i; break; end
    end
    if (cyc == 0) begin
      errors++;
      $display("FAIL wait_done0: done never seen within 600 cycles");
    end
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin cyc = i; break; end
    end
    if (cyc == 0) begin
      errors++;
      $display("FAIL wait_done1: done never seen within 600 cycles");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus0.avm_read !== 1'b0) begin errors++; $display("FAIL rst_read0 got %0b want 0", bus0.avm_read); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %0b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done0 got %0b want 0", done0); end
    checks++; if ({pass0, idm0, tsm0, to0} !== 4'b0) begin errors++; $display("FAIL rst_flags0 got %b want 0000", {pass0, idm0, tsm0, to0}); end
    checks++; if ({cid0, cts0} !== 64'd0) begin errors++; $display("FAIL rst_caps0 got %h want 0", {cid0, cts0}); end
    checks++; if (bus1.avm_read !== 1'b0) begin errors++; $display("FAIL rst_read1 got %0b want 0", bus1.avm_read); end
    @(negedge clk); rst1_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy1, bus1.avm_read, done1} !== 3'b000) begin errors++; $display("FAIL noauto1 got %b want 000", {busy1, bus1.avm_read, done1}); end
  endtask

  task automatic test_auto_start();
    int n;
    logic [1:0] rd_addr1, rd_addr2;
    n = 0; rd_addr1 = 2'b00; rd_addr2 = 2'b00;
    @(negedge clk); rst0_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) rd_addr1 = {bus0.avm_read, bus0.avm_address};
      if (i == 2) rd_addr2 = {bus0.avm_read, bus0.avm_address};
      if (done0 === 1'b1) begin n = i; break; end
    end
    checks++; if (rd_addr1 !== 2'b10) begin errors++; $display("FAIL auto_id_req got %b want 10", rd_addr1); end
    checks++; if (rd_addr2 !== 2'b11) begin errors++; $display("FAIL auto_ts_req got %b want 11", rd_addr2); end
    checks++; if (n !== 3) begin errors++; $display("FAIL auto_done_cycle got %0d want 3", n); end
    checks++; if (pass0 !== 1'b1) begin errors++; $display("FAIL auto_pass got %0b want 1", pass0); end
    checks++; if (cts0 !== TS_OK) begin errors++; $display("FAIL auto_captured_ts got %0d want %0d", cts0, TS_OK); end
    checks++; if ({idm0, tsm0, to0} !== 3'b000) begin errors++; $display("FAIL auto_flags got %b want 000", {idm0, tsm0, to0}); end
    @(negedge clk);
    checks++; if ({done0, busy0, pass0} !== 3'b001) begin errors++; $display("FAIL auto_after got %b want 001", {done0, busy0, pass0}); end
  endtask

  task automatic test_ts_mismatch();
    int c;
    slave_ts0 = 32'h1234_5678;
    pulse_start0();
    wait_done0(c);
    checks++; if (c !== 2) begin errors++; $display("FAIL tsm_latency got %0d want 2", c); end
    checks++; if ({pass0, idm0, tsm0, to0} !== 4'b0010) begin errors++; $display("FAIL tsm_flags got %b want 0010", {pass0, idm0, tsm0, to0}); end
    checks++; if (cts0 !== 32'h1234_5678) begin errors++; $display("FAIL tsm_captured_ts got %h want 12345678", cts0); end
    slave_ts0 = TS_OK;
  endtask

  task automatic test_stall_id();
    int c, bad;
    bad = 0;
    @(negedge clk); start0 = 1'b1; wr0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (!(bus0.avm_read === 1'b1 && bus0.avm_address === SYSID_ADDR_ID)) bad++;
      if (i < 10) @(negedge clk);
    end
    wr0 = 1'b0;
    wait_done0(c);
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_stable got %0d bad cycles want 0", bad); end
    checks++; if (c !== 2) begin errors++; $display("FAIL stall_finish got %0d want 2", c); end
    checks++; if ({pass0, to0} !== 2'b10) begin errors++; $display("FAIL stall_result got %b want 10", {pass0, to0}); end
  endtask

  task automatic test_timeout();
    int rd_cnt, ts_rd, done_cnt;
    rd_cnt = 0; ts_rd = 0; done_cnt = 0;
    wr1 = 1'b1;
    pulse_start1();
    for (int i = 0; i < 20; i++) begin
      if (bus1.avm_read === 1'b1) rd_cnt++;
      if (bus1.avm_read === 1'b1 && bus1.avm_address === SYSID_ADDR_TS) ts_rd++;
      if (done1 === 1'b1) done_cnt++;
      @(negedge clk);
    end
    wr1 = 1'b0;
    checks++; if (rd_cnt !== 8) begin errors++; $display("FAIL to_read_cycles got %0d want 8", rd_cnt); end
    checks++; if (ts_rd !== 0) begin errors++; $display("FAIL to_ts_read got %0d want 0", ts_rd); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL to_done_pulses got %0d want 1", done_cnt); end
    checks++; if ({to1, pass1, busy1} !== 3'b100) begin errors++; $display("FAIL to_flags got %b want 100", {to1, pass1, busy1}); end
  endtask

  task automatic test_latency();
    int c;
    slave_id1 = 32'd0; slave_ts1 = TS_OK;
    pulse_start1();
    wait_done1(c);
    checks++; if (c !== 6) begin errors++; $display("FAIL lat_duration got %0d want 6", c); end
    checks++; if ({pass1, idm1, tsm1, to1} !== 4'b1000) begin errors++; $display("FAIL lat_flags got %b want 1000", {pass1, idm1, tsm1, to1}); end
    checks++; if ({cid1, cts1} !== {32'd0, TS_OK}) begin errors++; $display("FAIL lat_caps got %h want %h", {cid1, cts1}, {32'd0, TS_OK}); end
    slave_id1 = 32'hA5A5_0001;
    pulse_start1();
    wait_done1(c);
    checks++; if ({pass1, idm1, tsm1, to1} !== 4'b0100) begin errors++; $display("FAIL lat_idm_flags got %b want 0100", {pass1, idm1, tsm1, to1}); end
    checks++; if ({cid1, cts1} !== {32'hA5A5_0001, TS_OK}) begin errors++; $display("FAIL lat_idm_caps got %h want %h", {cid1, cts1}, {32'hA5A5_0001, TS_OK}); end
  endtask

  task automatic test_busy_start();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk); start0 = 1'b1; wr0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    checks++; if ({busy0, bus0.avm_read, bus0.avm_address} !== 3'b110) begin errors++; $display("FAIL busy_hold got %b want 110", {busy0, bus0.avm_read, bus0.avm_address}); end
    @(negedge clk); wr0 = 1'b0;
    // start is raised on the FIN cycle and must not relaunch
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin done_cnt++; start0 = 1'b1; end
      else start0 = 1'b0;
    end
    start0 = 1'b0;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt); end
    checks++; if ({busy0, pass0} !== 2'b01) begin errors++; $display("FAIL busy_end got %b want 01", {busy0, pass0}); end
  endtask

  task automatic test_reset_mid();
    int c;
    slave_id0 = 32'h0000_0BAD; wr0 = 1'b0;
    pulse_start0();
    @(negedge clk); wr0 = 1'b1;
    checks++; if ({bus0.avm_read, bus0.avm_address, idm0} !== 3'b111) begin errors++; $display("FAIL mid_ts_req got %b want 111", {bus0.avm_read, bus0.avm_address, idm0}); end
    @(negedge clk);
    #2 rst0_n = 1'b0;
    #1;
    checks++; if ({bus0.avm_read, busy0, done0} !== 3'b000) begin errors++; $display("FAIL mid_reset_bus got %b want 000", {bus0.avm_read, busy0, done0}); end
    checks++; if ({pass0, idm0, tsm0, to0, (cid0 != 32'd0)} !== 5'b0) begin errors++; $display("FAIL mid_reset_flags got %b want 00000", {pass0, idm0, tsm0, to0, (cid0 != 32'd0)}); end
    slave_id0 = 32'd0; wr0 = 1'b0;
    @(negedge clk); rst0_n = 1'b1;
    wait_done0(c);
    checks++; if (c !== 3) begin errors++; $display("FAIL restart_cycle got %0d want 3", c); end
    checks++; if ({pass0, idm0, tsm0, to0} !== 4'b1000) begin errors++; $display("FAIL restart_flags got %b want 1000", {pass0, idm0, tsm0, to0}); end
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0;
    slave_id0 = 32'd0; slave_ts0 = TS_OK; slave_id1 = 32'd0; slave_ts1 = TS_OK;
    test_reset();
    test_auto_start();
    test_ts_mismatch();
    test_stall_id();
    test_timeout();
    test_latency();
    test_busy_start();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
